// File: rtl/ask_uart_byte_receiver_pkg.sv
// Shared definitions for the ASK UART byte receiver: receiver state encoding
// and the mid-bit sample offset helper.
package ask_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_e;

  localparam int DEF_SAMPLES_PER_BIT = 16;
  localparam int HALF                = DEF_SAMPLES_PER_BIT / 2;

  // Mid-bit sample offset for a given oversampling ratio.
  function automatic int half_of(input int spb);
    return spb / 2;
  endfunction

endpackage

// File: rtl/ask_uart_byte_receiver_if.sv
// Single-word AXI-stream style output channel for received characters.
interface ask_uart_byte_receiver_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] o_tdata;
  logic                 o_tvalid;
  logic                 o_tready;

  modport master (output o_tdata, output o_tvalid, input o_tready);
  modport slave  (input o_tdata, input o_tvalid, output o_tready);
endinterface

// File: rtl/ask_uart_byte_receiver.sv
// 8N1 character recovery from the sliced ASK detector line, advancing on the
// detector sample strobe, with a one-word holding register on the output.
module ask_uart_byte_receiver
  import ask_pkg::*;
#(
  parameter int SAMPLES_PER_BIT = 16,
  parameter int DATA_BITS       = 8,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     enable,
  input  logic                     rx,
  input  logic                     rx_tick,
  ask_uart_byte_receiver_if.master axis,
  output logic                     framing_error,
  output logic                     overrun
);

  localparam int HALF_BIT = half_of(SAMPLES_PER_BIT);
  localparam int IDX_W    = $clog2(DATA_BITS + 1);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_HALF = CNT_WIDTH'(HALF_BIT);
  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(SAMPLES_PER_BIT);
  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(DATA_BITS - 1);

  generate
    if ($clog2(SAMPLES_PER_BIT * (DATA_BITS + 2) + 1) > CNT_WIDTH) begin : g_cnt_chk
      $error("CNT_WIDTH too small for SAMPLES_PER_BIT*(DATA_BITS+2)");
    end
    if ((SAMPLES_PER_BIT < 4) || (SAMPLES_PER_BIT % 2 != 0)) begin : g_spb_chk
      $error("SAMPLES_PER_BIT must be even and >= 4");
    end
  endgenerate

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   tdata_q, tdata_d;
  logic                   tvalid_q, tvalid_d;
  logic                   fe_q, fe_d;
  logic                   ov_q, ov_d;
  logic                   adv;
  logic                   done;

  assign adv = rx_tick & enable;

  // Bit timing: the counter restarts at 1 on every sample so each sample lands
  // a full bit period after the previous one, starting from mid start bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    fe_d    = 1'b0;
    done    = 1'b0;
    if (adv) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!rx) begin
            state_d = ST_START;
            cnt_d   = CNT_ONE;
          end
        end
        ST_START: begin
          if (cnt_q == CNT_HALF) begin
            if (!rx) begin
              state_d = ST_DATA;
              cnt_d   = CNT_ONE;
              idx_d   = '0;
            end else begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt_q == CNT_FULL) begin
            shift_d = {rx, shift_q[DATA_BITS-1:1]};
            cnt_d   = CNT_ONE;
            if (idx_q == IDX_LAST) begin
              state_d = ST_STOP;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_STOP: begin
          if (cnt_q == CNT_FULL) begin
            cnt_d = '0;
            if (rx) begin
              done    = 1'b1;
              state_d = ST_IDLE;
            end else begin
              fe_d    = 1'b1;
              state_d = ST_BREAK;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_BREAK: begin
          // Wait for mark before re-arming so a held-low line is not a start bit.
          if (rx) state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Holding register: a completion may replace the word only if the slot is
  // empty or being accepted on this same edge; otherwise it is an overrun.
  always_comb begin
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    ov_d     = 1'b0;
    if (done) begin
      if (!tvalid_q || axis.o_tready) begin
        tdata_d  = shift_q;
        tvalid_d = 1'b1;
      end else begin
        ov_d = 1'b1;
      end
    end else if (tvalid_q && axis.o_tready) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      fe_q     <= 1'b0;
      ov_q     <= 1'b0;
    end else if (clear) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      fe_q     <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      fe_q     <= fe_d;
      ov_q     <= ov_d;
    end
  end

  assign axis.o_tdata   = tdata_q;
  assign axis.o_tvalid  = tvalid_q;
  assign framing_error  = fe_q;
  assign overrun        = ov_q;

endmodule

// File: doc/ask_uart_byte_receiver.md
Name: ask_uart_byte_receiver

Overview:
Downstream stage of the automatic-threshold ASK detector. It consumes the detector's sliced `rx` bit stream (idle/mark = 1), advancing on the same sample strobe that clocks the detector. It recovers 8N1 asynchronous characters by counting samples per bit, and presents each byte on a single-word AXI-stream output. It also reports framing and overrun events for the radio link statistics block.

Parameters:
SAMPLES_PER_BIT, 16, detector samples per data bit; even, >= 4
DATA_BITS, 8, data bits per character, LSB first, no parity
CNT_WIDTH, 8, width of the sample counter; must hold SAMPLES_PER_BIT*(DATA_BITS+2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-low (asserted when 0)
clear  in  1  synchronous clear, active-high; same effect as reset
enable  in  1  block enable; when low, no state advances
rx  in  1  sliced line from the ASK detector, 1 = idle/mark
rx_tick  in  1  sample strobe; the same i_tvalid & enable that advances the detector
o_tdata  out  DATA_BITS  received character
o_tvalid  out  1  character valid
o_tready  in  1  downstream accept
framing_error  out  1  one-clk pulse: stop bit sampled 0
overrun  out  1  one-clk pulse: character completed while o_tvalid still held

Behaviour:
- Reset or clear: state IDLE, counter 0, shift register 0, o_tdata 0, o_tvalid 0, framing_error 0, overrun 0.
- Reset takes effect immediately, mid-character or mid-handshake; it drops any held byte.
- Advance condition `adv = rx_tick & enable`. Nothing except the output handshake changes on clocks where adv is 0.
- Let HALF = SAMPLES_PER_BIT/2. Tick 0 is the adv tick on which IDLE sees rx == 0.
- State IDLE: on adv with rx == 0, go to START with counter = 1.
- State START: on each adv, increment the counter.
  - At counter == HALF, sample rx.
  - If rx == 0, go to DATA, counter = 1, bit index = 0.
  - Else (glitch), return to IDLE.
- State DATA: on each adv, increment the counter.
  - At counter == SAMPLES_PER_BIT, shift rx into the MSB of the shift register (right shift, LSB first), counter = 1, bit index + 1.
  - After DATA_BITS samples, go to STOP.
  - Net effect: bit k is sampled at tick HALF + (k+1)*SAMPLES_PER_BIT.
- State STOP: at counter == SAMPLES_PER_BIT, sample rx.
  - If rx == 1, complete the character and go to IDLE.
  - If rx == 0, pulse framing_error for one clk, discard the byte, and go to BREAK.
- State BREAK: stay until an adv with rx == 1, then go to IDLE. A new start bit is never accepted from BREAK directly.
- Completion with o_tvalid == 0: o_tdata <= shift register and o_tvalid <= 1 on the same clk edge as the stop sample. Latency is one clk after the stop adv tick.
- Completion with o_tvalid == 1 and o_tready == 0: the new byte is dropped, the held byte is kept, and overrun pulses for one clk.
- Completion on the same clk as an accept (o_tvalid & o_tready): the new byte replaces the old one, o_tvalid stays 1, and no overrun is reported.
- Handshake: o_tvalid deasserts on the clk after o_tvalid & o_tready, unless a completion coincides. o_tdata is stable while o_tvalid is held.
- enable low mid-character freezes the state machine and counter, and resumes exactly where it stopped. The output handshake still operates while enable is low.
- Counter arithmetic is unsigned in CNT_WIDTH bits. It never wraps in legal configurations; elaboration fails if CNT_WIDTH is too small.

Decomposition:
- Shared package (`ask_pkg`): state encoding constants (IDLE, START, DATA, STOP, BREAK, 3 bits), and HALF derived from SAMPLES_PER_BIT.
- Single module; no sub-module. The bit-timing counter and the one-word output holding register remain inline.

Test Plan:
- Byte 0x55, SAMPLES_PER_BIT=16, rx_tick every clk, o_tready=1 -> o_tdata=0x55 with o_tvalid for exactly 1 clk. It rises 1 clk after tick 152 (8 + 9*16), counted from the falling-edge tick.
- 5-tick low glitch on idle line -> START aborts at tick 8, no o_tvalid, no framing_error, state back in IDLE.
- 0xA3 sent with the stop bit forced 0 for 40 ticks -> framing_error pulses once, no o_tvalid. A following 0x3C is received only after rx returns to 1.
- Two bytes 0x11, 0x22 back-to-back with o_tready=0 -> o_tdata holds 0x11, overrun pulses at the second stop. Raising o_tready then yields 0x11 only.
- rx_tick every 4th clk with enable dropped for 20 clks mid-bit 3 of 0xC8 -> 0xC8 still received correctly.
- reset driven low mid-DATA of 0x7E -> o_tvalid 0 immediately. After release, the next full 0x81 is received correctly.
